// File: rtl/ibex_data_responder.sv
// ibex_data_responder
//   Device-side end of the Ibex data-port req/gnt/rvalid protocol. Each
//   request is decoded to the shared RAM or to a small test-utility window
//   (HALT, SIG, CYCLE), granted after a configurable stall, and answered one
//   cycle after the grant with read data or an error.
//
//   Optional feature macro: DATA_RESP_RAND_STALL_EN
//     defined   - stall count comes from a 3-bit LFSR stepped once per grant
//     undefined - stall count is the WaitCycles parameter
//
// Ports
//   clk_i, rst_ni                system clock, async active-low reset
//   host_req_i .. host_wdata_i   core data request channel
//   host_gnt_o                   grant (combinational from req and state)
//   host_rvalid_o/rdata_o/err_o  response, one cycle after grant
//   ram_*                        RAM request, valid in the grant cycle only;
//                                ram_rdata_i is valid the following cycle
//   halt_o, halt_code_o          sticky end-of-test flag and its code
//   sig_valid_o, sig_data_o      signature word strobe and held data
module ibex_data_responder #(
    parameter logic [31:0] RamAddrBase  = 32'h0000_0000,
    parameter logic [31:0] RamAddrMask  = 32'hFFFF_0000,
    parameter logic [31:0] UtilAddrBase = 32'h0002_0000,
    parameter logic [31:0] UtilAddrMask = 32'hFFFF_FC00,
    parameter int unsigned WaitCycles   = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        host_req_i,
    output logic        host_gnt_o,
    input  logic [31:0] host_addr_i,
    input  logic        host_we_i,
    input  logic [3:0]  host_be_i,
    input  logic [31:0] host_wdata_i,
    output logic        host_rvalid_o,
    output logic [31:0] host_rdata_o,
    output logic        host_err_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,

    output logic        halt_o,
    output logic [31:0] halt_code_o,
    output logic        sig_valid_o,
    output logic [31:0] sig_data_o
);

    localparam int unsigned CntW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] stall_cnt;
    logic            gnt;

    // Stall count source
`ifdef DATA_RESP_RAND_STALL_EN
    logic [CntW-1:0] lfsr_q;

    // x^3 + x^2 + 1 Fibonacci LFSR, advanced once per granted request
    always_ff @(posedge clk_i or negedge rst_ni) begin : p_lfsr
        if (!rst_ni) begin
            lfsr_q <= CntW'(1);
        end else if (gnt) begin
            lfsr_q <= {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
        end
    end

    assign stall_cnt = lfsr_q;
`else
    assign stall_cnt = CntW'(WaitCycles);
`endif

    // State and stall counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin : p_state_reg
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a dropped request during STALL abandons the access
    always_comb begin : p_next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (host_req_i) begin
                    if (stall_cnt == '0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = stall_cnt;
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (!host_req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Grant: never issued in RESP, so back-to-back grants are >= 2 cycles apart
    always_comb begin : p_output
        gnt = 1'b0;
        case (state_q)
            IDLE:    gnt = host_req_i && (stall_cnt == '0);
            STALL:   gnt = host_req_i && (cnt_q == CntW'(1));
            default: gnt = 1'b0;
        endcase
    end

    assign host_gnt_o = gnt;

    // Address decode; RAM window takes priority over the utility window
    logic        ram_hit;
    logic        util_hit;
    logic [31:0] util_off;
    logic        halt_wr;
    logic        sig_wr;
    logic        cyc_rd;
    logic        acc_err;

    assign ram_hit  = (host_addr_i & RamAddrMask) == RamAddrBase;
    assign util_hit = !ram_hit && ((host_addr_i & UtilAddrMask) == UtilAddrBase);
    assign util_off = host_addr_i & ~UtilAddrMask;
    assign halt_wr  = util_hit &&  host_we_i && (util_off == 32'h0000_0000);
    assign sig_wr   = util_hit &&  host_we_i && (util_off == 32'h0000_0004);
    assign cyc_rd   = util_hit && !host_we_i && (util_off == 32'h0000_0008);
    assign acc_err  = !(ram_hit || halt_wr || sig_wr || cyc_rd);

    // RAM channel passes the request through in the grant cycle only
    assign ram_req_o   = gnt && ram_hit;
    assign ram_we_o    = ram_req_o && host_we_i;
    assign ram_be_o    = ram_req_o ? host_be_i    : 4'h0;
    assign ram_addr_o  = ram_req_o ? host_addr_i  : 32'h0;
    assign ram_wdata_o = ram_req_o ? host_wdata_i : 32'h0;

    // Response registers, loaded at grant
    logic        rvalid_q;
    logic        err_q;
    logic        ram_rd_q;
    logic [31:0] rdata_q;
    logic [31:0] cycle_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin : p_resp
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            ram_rd_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt;
            err_q    <= gnt && acc_err;
            ram_rd_q <= gnt && ram_hit && !host_we_i;
            rdata_q  <= (gnt && cyc_rd) ? cycle_q : 32'h0;
        end
    end

    assign host_rvalid_o = rvalid_q;
    assign host_err_o    = err_q;
    // RAM read data arrives in the response cycle; everything else is held
    assign host_rdata_o  = ram_rd_q ? ram_rdata_i : rdata_q;

    // Test-utility state: sticky halt, signature strobe, free-running cycles
    logic        halt_q;
    logic [31:0] halt_code_q;
    logic        sig_valid_q;
    logic [31:0] sig_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin : p_util
        if (!rst_ni) begin
            halt_q      <= 1'b0;
            halt_code_q <= '0;
            sig_valid_q <= 1'b0;
            sig_data_q  <= '0;
            cycle_q     <= '0;
        end else begin
            cycle_q     <= cycle_q + 32'd1;
            sig_valid_q <= gnt && sig_wr;
            if (gnt && sig_wr) begin
                sig_data_q <= host_wdata_i;
            end
            if (gnt && halt_wr && !halt_q) begin
                halt_q      <= 1'b1;
                halt_code_q <= host_wdata_i;
            end
        end
    end

    assign halt_o      = halt_q;
    assign halt_code_o = halt_code_q;
    assign sig_valid_o = sig_valid_q;
    assign sig_data_o  = sig_data_q;

endmodule

// File: tb/tb_ibex_data_responder.sv
// Bench for ibex_data_responder: instance 0 with WaitCycles=0, instance 1
// with WaitCycles=3, each with its own behavioural RAM. Directed scenarios
// plus random traffic are scored against a word-level model of the windows.
module tb_ibex_data_responder;

    localparam int unsigned WaitStep = 3;
    localparam int unsigned RamWords = 16384;

    logic clk;
    logic rst_n;

    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0][31:0] ram_rdata;

    wire  [1:0]       gnt;
    wire  [1:0]       rvalid;
    wire  [1:0]       err;
    wire  [1:0][31:0] rdata;
    wire  [1:0]       ram_req;
    wire  [1:0]       ram_we;
    wire  [1:0][3:0]  ram_be;
    wire  [1:0][31:0] ram_addr;
    wire  [1:0][31:0] ram_wdata;
    wire  [1:0]       halt;
    wire  [1:0][31:0] halt_code;
    wire  [1:0]       sig_valid;
    wire  [1:0][31:0] sig_data;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ibex_data_responder #(
            .WaitCycles(g * WaitStep)
        ) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .host_req_i   (req[g]),
            .host_gnt_o   (gnt[g]),
            .host_addr_i  (addr[g]),
            .host_we_i    (we[g]),
            .host_be_i    (be[g]),
            .host_wdata_i (wdata[g]),
            .host_rvalid_o(rvalid[g]),
            .host_rdata_o (rdata[g]),
            .host_err_o   (err[g]),
            .ram_req_o    (ram_req[g]),
            .ram_we_o     (ram_we[g]),
            .ram_be_o     (ram_be[g]),
            .ram_addr_o   (ram_addr[g]),
            .ram_wdata_o  (ram_wdata[g]),
            .ram_rdata_i  (ram_rdata[g]),
            .halt_o       (halt[g]),
            .halt_code_o  (halt_code[g]),
            .sig_valid_o  (sig_valid[g]),
            .sig_data_o   (sig_data[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAMs seen by each responder (one-cycle read latency)
    bit [31:0] ram_mem [2][RamWords];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_req[k]) begin
                if (ram_we[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ram_be[k][b]) begin
                            ram_mem[k][ram_addr[k][15:2]][8*b +: 8] <= ram_wdata[k][8*b +: 8];
                        end
                    end
                end
                ram_rdata[k] <= ram_mem[k][ram_addr[k][15:2]];
            end
        end
    end

    // Reference model state
    bit [31:0] exp_mem [2][RamWords];
    bit        exp_halt      [2];
    bit [31:0] exp_halt_code [2];
    bit [31:0] exp_sig_data  [2];
    int        grant_cnt     [2];
    int        lfsr_tab      [7] = '{1, 2, 5, 3, 7, 6, 4};
    int unsigned cyc_since_rst;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_since_rst <= 0;
        else        cyc_since_rst <= cyc_since_rst + 1;
    end

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_stall(input int k);
`ifdef DATA_RESP_RAND_STALL_EN
        return lfsr_tab[grant_cnt[k] % 7];
`else
        return k * int'(WaitStep);
`endif
    endfunction

    task automatic idle_inputs(input int k);
        req[k]   = 1'b0;
        we[k]    = 1'b0;
        be[k]    = 4'h0;
        addr[k]  = 32'h0;
        wdata[k] = 32'h0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_halt[k]      = 1'b0;
            exp_halt_code[k] = 32'h0;
            exp_sig_data[k]  = 32'h0;
            grant_cnt[k]     = 0;
        end
    endtask

    // One complete transaction on instance k, scored against the model
    task automatic txn(input int k, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d);
        int          lat;
        bit          got;
        bit          m_ram;
        bit          m_err;
        bit          m_sigv;
        logic [31:0] m_rd;
        logic [31:0] off;

        @(posedge clk); #1;
        addr[k] = a; we[k] = w; be[k] = b; wdata[k] = d; req[k] = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat <= 16) begin
            @(negedge clk);
            if (gnt[k]) begin
                got = 1'b1;
            end else begin
                check("stall_ram_req", 32'(ram_req[k]), 32'h0);
                check("stall_rvalid", 32'(rvalid[k]), 32'h0);
                lat++;
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            check("gnt_timeout", 32'h0, 32'h1);
            idle_inputs(k);
            return;
        end
        check("gnt_latency", 32'(lat), 32'(exp_stall(k)));
        grant_cnt[k]++;

        m_ram  = a < 32'h0001_0000;
        m_err  = 1'b0;
        m_sigv = 1'b0;
        m_rd   = 32'h0;
        off    = a - 32'h0002_0000;
        if (m_ram) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) exp_mem[k][a[15:2]][8*i +: 8] = d[8*i +: 8];
            end else begin
                m_rd = exp_mem[k][a[15:2]];
            end
        end else if (a >= 32'h0002_0000 && a < 32'h0002_0400 && off == 32'h0 && w) begin
            if (!exp_halt[k]) begin
                exp_halt[k]      = 1'b1;
                exp_halt_code[k] = d;
            end
        end else if (a >= 32'h0002_0000 && a < 32'h0002_0400 && off == 32'h4 && w) begin
            m_sigv          = 1'b1;
            exp_sig_data[k] = d;
        end else if (a >= 32'h0002_0000 && a < 32'h0002_0400 && off == 32'h8 && !w) begin
            m_rd = cyc_since_rst;
        end else begin
            m_err = 1'b1;
        end

        check("ram_req", 32'(ram_req[k]), 32'(m_ram));
        if (m_ram) check("ram_addr", ram_addr[k], a);

        @(posedge clk); #1;
        idle_inputs(k);
        @(negedge clk);
        check("rvalid", 32'(rvalid[k]), 32'h1);
        check("err", 32'(err[k]), 32'(m_err));
        check("rdata", rdata[k], m_rd);
        check("sig_valid", 32'(sig_valid[k]), 32'(m_sigv));
        check("sig_data", sig_data[k], exp_sig_data[k]);
        check("halt", 32'(halt[k]), 32'(exp_halt[k]));
        check("halt_code", halt_code[k], exp_halt_code[k]);
        @(negedge clk);
        check("rvalid_single", 32'(rvalid[k]), 32'h0);
        check("rdata_idle", rdata[k], 32'h0);
        check("sig_valid_single", 32'(sig_valid[k]), 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1, 2: return 32'($urandom_range(0, 31)) << 2;
            3:       return 32'h0000_FF80 + (32'($urandom_range(0, 31)) << 2);
            4:       return 32'h0002_0000 + (32'($urandom_range(0, 3)) << 2);
            default: begin
                case ($urandom_range(0, 4))
                    0:       return 32'h0001_0000;
                    1:       return 32'h0001_FFFC;
                    2:       return 32'h0002_03FC;
                    3:       return 32'h0002_0400;
                    default: return 32'h0003_0000;
                endcase
            end
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic        w;
        logic [3:0]  b;

        n_vec = 0;
        n_err = 0;
        idle_inputs(0);
        idle_inputs(1);
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_gnt", 32'(gnt[k]), 32'h0);
            check("rst_rvalid", 32'(rvalid[k]), 32'h0);
            check("rst_rdata", rdata[k], 32'h0);
            check("rst_err", 32'(err[k]), 32'h0);
            check("rst_ram_req", 32'(ram_req[k]), 32'h0);
            check("rst_ram_addr", ram_addr[k], 32'h0);
            check("rst_halt", 32'(halt[k]), 32'h0);
            check("rst_halt_code", halt_code[k], 32'h0);
            check("rst_sig_valid", 32'(sig_valid[k]), 32'h0);
            check("rst_sig_data", sig_data[k], 32'h0);
        end
        rst_n = 1'b1;

        // RAM write/read, zero and three stall cycles
        txn(0, 32'h0000_0100, 1'b1, 4'hF, 32'hDEAD_BEEF);
        txn(0, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
        txn(1, 32'h0000_0100, 1'b1, 4'hF, 32'h1234_5678);
        txn(1, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
        // Byte enables, including an empty write
        txn(0, 32'h0000_0100, 1'b1, 4'h0, 32'h1111_1111);
        txn(0, 32'h0000_0100, 1'b1, 4'h5, 32'hAABB_CCDD);
        txn(0, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
        // RAM window edges
        txn(0, 32'h0000_FFFC, 1'b1, 4'hF, 32'hCAFE_F00D);
        txn(0, 32'h0000_FFFC, 1'b0, 4'hF, 32'h0);
        txn(0, 32'h0001_0000, 1'b0, 4'hF, 32'h0);
        // HALT is sticky, SIG strobes
        txn(0, 32'h0002_0000, 1'b1, 4'hF, 32'h0000_0001);
        txn(0, 32'h0002_0000, 1'b1, 4'hF, 32'h0000_0005);
        txn(0, 32'h0002_0004, 1'b1, 4'hF, 32'hA5A5_A5A5);
        txn(1, 32'h0002_0004, 1'b1, 4'hF, 32'h5A5A_5A5A);
        // Error responses
        txn(0, 32'h0003_0000, 1'b0, 4'hF, 32'h0);
        txn(0, 32'h0002_0000, 1'b0, 4'hF, 32'h0);
        txn(0, 32'h0002_0008, 1'b1, 4'hF, 32'h0000_0099);
        txn(1, 32'h0002_000C, 1'b0, 4'hF, 32'h0);
        // CYCLE read
        txn(0, 32'h0002_0008, 1'b0, 4'hF, 32'h0);
        txn(1, 32'h0002_0008, 1'b0, 4'hF, 32'h0);

        // Abandoned request during stall produces nothing
        @(posedge clk); #1;
        addr[1] = 32'h0000_0040; req[1] = 1'b1;
        @(posedge clk); #1;
        idle_inputs(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abandon_gnt", 32'(gnt[1]), 32'h0);
            check("abandon_rvalid", 32'(rvalid[1]), 32'h0);
        end

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            a = rand_addr();
            w = 1'($urandom_range(0, 1));
            b = (a < 32'h0001_0000) ? 4'($urandom_range(0, 15)) : 4'hF;
            txn(i % 2, a, w, b, $urandom);
        end

        // Reset between grant and response drops the response and clears halt
        @(posedge clk); #1;
        addr[0] = 32'h0002_0000; we[0] = 1'b1; be[0] = 4'hF;
        wdata[0] = 32'h0000_0077; req[0] = 1'b1;
        @(negedge clk);
        check("midrst_gnt", 32'(gnt[0]), 32'h1);
        rst_n = 1'b0;
        idle_inputs(0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_rvalid", 32'(rvalid[0]), 32'h0);
        end
        check("midrst_halt", 32'(halt[0]), 32'h0);
        check("midrst_halt_code", halt_code[0], 32'h0);
        check("midrst_sig_data", sig_data[0], 32'h0);
        txn(0, 32'h0002_0008, 1'b0, 4'hF, 32'h0);
        txn(1, 32'h0000_0100, 1'b0, 4'hF, 32'h0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
